cmp_strobe_sampler: RTL

- Comparator strobe and sampling front-end that sits directly upstream of the skew measurement controller.
- On each strobe request it waits for the delay line to settle after a delay-code change, then fires N latch strobes into the master and slave comparators.
- It majority-votes the synchronised comparator outputs and returns stable m_cmp_o/s_cmp_o with a one-cycle stb_valid_o.
- Filters comparator metastability and noise so the controller's edge search sees a clean decision per delay code.

---
 rtl/cmp_strobe_sampler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cmp_strobe_sampler.sv
// Comparator strobe/sampling front-end: settles after a delay-code change, fires
// N latch strobes, majority-votes the synchronised comparator outputs.
module cmp_strobe_sampler #(
  parameter int SETTLE_CYCLES = 16,
  parameter int N_SAMPLES     = 8,
  parameter int SAMPLE_DLY    = 3,
  parameter int STB_GAP       = 4
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic stb_req_i,
  input  logic clr_i,
  input  logic m_cmp_raw_i,
  input  logic s_cmp_raw_i,
  output logic stb_o,
  output logic m_cmp_o,
  output logic s_cmp_o,
  output logic stb_valid_o,
  output logic busy_o
);

  localparam int HW      = $clog2(N_SAMPLES + 1);
  localparam int DLY_MAX = (SETTLE_CYCLES > SAMPLE_DLY)
                         ? ((SETTLE_CYCLES > STB_GAP) ? SETTLE_CYCLES : STB_GAP)
                         : ((SAMPLE_DLY > STB_GAP) ? SAMPLE_DLY : STB_GAP);
  localparam int CW      = $clog2(DLY_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LOAD   = CW'(SAMPLE_DLY - 1);
  localparam logic [CW-1:0] GAP_LOAD    = CW'((STB_GAP > 0) ? STB_GAP - 1 : 0);
  localparam logic [HW-1:0] N_LAST      = HW'(N_SAMPLES - 1);
  localparam logic [HW:0]   N_CMP       = (HW + 1)'(N_SAMPLES);

  typedef enum logic [2:0] {
    IDLE, SETTLE, STROBE, WAIT_SMP, SAMPLE, GAP, DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] smp_cnt_q;
  logic [HW-1:0] m_hits_q, s_hits_q;
  logic [1:0]    m_sync_q, s_sync_q;
  logic [HW-1:0] m_hits_nxt, s_hits_nxt;

  // Strict majority: 2*hits > N, evaluated one bit wider so it cannot overflow.
  function automatic logic vote(input logic [HW-1:0] hits);
    return {hits, 1'b0} > N_CMP;
  endfunction

  // Hit totals including the sample taken this cycle, so the vote at the
  // edge entering DONE already counts the final strobe.
  assign m_hits_nxt = m_hits_q + HW'(m_sync_q[1]);
  assign s_hits_nxt = s_hits_q + HW'(s_sync_q[1]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_sync_q <= '0;
      s_sync_q <= '0;
    end else begin
      m_sync_q <= {m_sync_q[0], m_cmp_raw_i};
      s_sync_q <= {s_sync_q[0], s_cmp_raw_i};
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      smp_cnt_q   <= '0;
      m_hits_q    <= '0;
      s_hits_q    <= '0;
      stb_o       <= 1'b0;
      stb_valid_o <= 1'b0;
      m_cmp_o     <= 1'b0;
      s_cmp_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle; only the transitions that
      // own a pulse raise it, which keeps them single-cycle by construction.
      stb_o       <= 1'b0;
      stb_valid_o <= 1'b0;
      if (clr_i) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        smp_cnt_q <= '0;
        m_hits_q  <= '0;
        s_hits_q  <= '0;
        busy_o    <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (stb_req_i) begin
            state_q   <= SETTLE;
            cnt_q     <= SETTLE_LOAD;
            smp_cnt_q <= '0;
            m_hits_q  <= '0;
            s_hits_q  <= '0;
            busy_o    <= 1'b1;
          end
          SETTLE:
            if (cnt_q == '0) begin
              state_q <= STROBE;
              stb_o   <= 1'b1;
            end else cnt_q <= cnt_q - CW'(1);
          STROBE: begin
            state_q <= WAIT_SMP;
            cnt_q   <= WAIT_LOAD;
          end
          WAIT_SMP:
            if (cnt_q == '0) state_q <= SAMPLE;
            else             cnt_q   <= cnt_q - CW'(1);
          SAMPLE: begin
            m_hits_q  <= m_hits_nxt;
            s_hits_q  <= s_hits_nxt;
            smp_cnt_q <= smp_cnt_q + HW'(1);
            if (smp_cnt_q == N_LAST) begin
              state_q     <= DONE;
              stb_valid_o <= 1'b1;
              m_cmp_o     <= vote(m_hits_nxt);
              s_cmp_o     <= vote(s_hits_nxt);
            end else if (STB_GAP == 0) begin
              state_q <= STROBE;
              stb_o   <= 1'b1;
            end else begin
              state_q <= GAP;
              cnt_q   <= GAP_LOAD;
            end
          end
          GAP:
            if (cnt_q == '0) begin
              state_q <= STROBE;
              stb_o   <= 1'b1;
            end else cnt_q <= cnt_q - CW'(1);
          DONE: begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
